mips_alu_pipe: RTL and testbench

- Parametrised, handshaked execution-stage ALU for the pipelined MIPS core; successor to the fixed 32-bit in-line EX logic.
- Accepts one operation per cycle: two operands, an op code and a destination tag. Returns the result, the tag and the flags after a configurable number of register stages.
- Supports backpressure from the writeback stage and a synchronous flush on branch or halt.

---
 rtl/mips_alu_pkg.sv | 26 ++
 rtl/mips_alu_pipe_if.sv | 31 +++
 rtl/mips_alu_core.sv | 65 ++++++
 rtl/mips_alu_pipe.sv | 70 +++++++
 tb/tb_mips_alu_pipe.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the pipelined MIPS execution-stage ALU:
// op codes, op-code width and the per-stage bundle layout.
`ifndef MIPS_ALU_STAGE_T
`define MIPS_ALU_STAGE_T(W, T) struct packed { logic valid; logic [(W)-1:0] result; logic [(T)-1:0] tag; logic zero; logic ovf; }
`endif

package mips_alu_pkg;

   localparam int ALU_OP_W = 4;

   // Codes 11..15 are unassigned and produce a zero result with no overflow.
   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_MUL  = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10
   } alu_op_t;

endpackage

// File: rtl/mips_alu_pipe_if.sv
// Operand/result handshake bundle between issue, the ALU pipe and writeback.
interface mips_alu_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   import mips_alu_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [ALU_OP_W-1:0] in_op;
   logic [WIDTH-1:0]    in_a;
   logic [WIDTH-1:0]    in_b;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_result;
   logic [TAG_W-1:0]    out_tag;
   logic                out_zero;
   logic                out_ovf;

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_zero, out_ovf
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_zero, out_ovf
   );

endinterface

// File: rtl/mips_alu_core.sv
// Combinational ALU: {op, a, b} -> {result, zero, ovf}.
module mips_alu_core
   import mips_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic [WIDTH-1:0]    result,
   output logic                zero,
   output logic                ovf
);

   localparam int SH_W = $clog2(WIDTH);

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic        [WIDTH-1:0] b_neg;
   logic        [WIDTH-1:0] sum;
   logic        [WIDTH-1:0] diff;
   logic        [SH_W-1:0]  shamt;

   // Overflow when both addends share a sign and the sum's sign differs.
   function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] r);
      return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   assign a_s   = a;
   assign b_s   = b;
   assign b_neg = ~b + WIDTH'(1);
   assign sum   = a + b;
   assign diff  = a + b_neg;
   assign shamt = b[SH_W-1:0];

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum;
            ovf    = add_ovf(a, b, sum);
         end
         OP_SUB: begin
            result = diff;
            ovf    = add_ovf(a, b_neg, diff);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MUL:  result = a * b;
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = a_s >>> shamt;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mips_alu_pipe.sv
// Handshaked EX-stage ALU with STAGES register stages, a global stall
// driven by writeback backpressure, and a synchronous flush.
module mips_alu_pipe
   import mips_alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic           clk1,
   input  logic           reset,
   input  logic           flush,
   mips_alu_pipe_if.slave bus
);

   typedef `MIPS_ALU_STAGE_T(WIDTH, TAG_W) stage_t;

   stage_t           stage_p [STAGES];
   stage_t           last_p;
   logic             advance;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_ovf;

   mips_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (bus.in_op),
      .a      (bus.in_a),
      .b      (bus.in_b),
      .result (alu_result),
      .zero   (alu_zero),
      .ovf    (alu_ovf)
   );

   // The whole pipe stalls together; bubbles are held in place too.
   assign last_p       = stage_p[STAGES-1];
   assign advance      = !last_p.valid || bus.out_ready;
   assign bus.in_ready = advance;

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_p[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_p[i].valid <= 1'b0;
         end
      end else if (advance) begin
         // stage 0: capture the combinational ALU result
         stage_p[0] <= '{valid:  bus.in_valid,
                         result: alu_result,
                         tag:    bus.in_tag,
                         zero:   alu_zero,
                         ovf:    alu_ovf};
         // stages 1..STAGES-1: carry the bundle forward
         for (int i = 1; i < STAGES; i++) begin
            stage_p[i] <= stage_p[i-1];
         end
      end
   end

   assign bus.out_valid  = last_p.valid;
   assign bus.out_result = last_p.valid ? last_p.result : '0;
   assign bus.out_tag    = last_p.valid ? last_p.tag    : '0;
   assign bus.out_zero   = last_p.valid && last_p.zero;
   assign bus.out_ovf    = last_p.valid && last_p.ovf;

endmodule

// File: tb/tb_mips_alu_pipe.sv
// Directed bench for mips_alu_pipe: 32-bit/2-stage and 8-bit/1-stage instances,
// with a queue of expected bundles pushed on input transfer and popped on output transfer.
module tb_mips_alu_pipe;
  import mips_alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  mips_alu_pipe_if #(.WIDTH(32), .TAG_W(5)) bus  ();
  mips_alu_pipe_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

  mips_alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
    .clk1  (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  mips_alu_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut8 (
    .clk1  (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus8.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        z;
    logic        v;
    int          t_in;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  exp_t        got;
  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc   = 0;
  int          base  = 0;
  bit          stall_en = 1'b0;
  bit          rdy      = 1'b1;
  bit          took     = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] h_res;
  logic [4:0]  h_tag;
  logic        h_z;
  logic        h_v;

  // One clock: drive out_ready, check everything at the falling edge, return just after the rising edge.
  task automatic step();
    bus.out_ready = rdy && !(stall_en && (cyc + 1 - base) >= 3 && (cyc + 1 - base) <= 5);
    @(negedge clk);
    cyc++;
    if (bus.out_valid && !bus.out_ready) begin
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_mis++; $error("FAIL in_ready_stalled: observed 0x%0h", bus.in_ready); end
    end else begin
      n_vec++;
      if (bus.in_ready !== 1'b1) begin n_mis++; $error("FAIL in_ready_free: observed 0x%0h", bus.in_ready); end
    end
    if (hold_prev) begin
      n_vec++;
      if (bus.out_valid !== 1'b1) begin n_mis++; $error("FAIL hold_valid: observed 0x%0h", bus.out_valid); end
      n_vec++;
      if (bus.out_result !== h_res) begin n_mis++; $error("FAIL hold_result: observed 0x%0h expected 0x%0h", bus.out_result, h_res); end
      n_vec++;
      if (bus.out_tag !== h_tag) begin n_mis++; $error("FAIL hold_tag: observed 0x%0h expected 0x%0h", bus.out_tag, h_tag); end
      n_vec++;
      if (bus.out_zero !== h_z) begin n_mis++; $error("FAIL hold_zero: observed 0x%0h expected 0x%0h", bus.out_zero, h_z); end
      n_vec++;
      if (bus.out_ovf !== h_v) begin n_mis++; $error("FAIL hold_ovf: observed 0x%0h expected 0x%0h", bus.out_ovf, h_v); end
    end
    hold_prev = bus.out_valid && !bus.out_ready && !flush && !reset;
    h_res = bus.out_result;
    h_tag = bus.out_tag;
    h_z   = bus.out_zero;
    h_v   = bus.out_ovf;
    if (bus.out_valid && bus.out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin n_mis++; $error("FAIL out_expected: unexpected output bundle"); end
      if (sb.size() != 0) begin
        got = sb.pop_front();
        n_vec++;
        if (bus.out_result !== got.res) begin n_mis++; $error("FAIL result: observed 0x%0h expected 0x%0h", bus.out_result, got.res); end
        n_vec++;
        if (bus.out_tag !== got.tag) begin n_mis++; $error("FAIL tag: observed 0x%0h expected 0x%0h", bus.out_tag, got.tag); end
        n_vec++;
        if (bus.out_zero !== got.z) begin n_mis++; $error("FAIL zero: observed 0x%0h expected 0x%0h", bus.out_zero, got.z); end
        n_vec++;
        if (bus.out_ovf !== got.v) begin n_mis++; $error("FAIL ovf: observed 0x%0h expected 0x%0h", bus.out_ovf, got.v); end
        if (got.lat) begin
          n_vec++;
          if (cyc - got.t_in != 2) begin n_mis++; $error("FAIL latency: observed %0d expected 2", cyc - got.t_in); end
        end
      end
    end else if (!bus.out_valid) begin
      n_vec++;
      if (bus.out_result !== 32'd0) begin n_mis++; $error("FAIL idle_result: observed 0x%0h", bus.out_result); end
      n_vec++;
      if (bus.out_tag !== 5'd0) begin n_mis++; $error("FAIL idle_tag: observed 0x%0h", bus.out_tag); end
      n_vec++;
      if (bus.out_zero !== 1'b0) begin n_mis++; $error("FAIL idle_zero: observed 0x%0h", bus.out_zero); end
      n_vec++;
      if (bus.out_ovf !== 1'b0) begin n_mis++; $error("FAIL idle_ovf: observed 0x%0h", bus.out_ovf); end
    end
    took = 1'b0;
    if (bus.in_valid && bus.in_ready && !flush && !reset) begin
      took     = 1'b1;
      cur.t_in = cyc;
      sb.push_back(cur);
    end
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] er, input logic ez,
                       input logic ev, input bit lat);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    cur.res = er;
    cur.tag = tag;
    cur.z   = ez;
    cur.v   = ev;
    cur.lat = lat;
    took    = 1'b0;
    for (int n = 0; n < 20 && !took; n++) step();
    n_vec++;
    if (took !== 1'b1) begin n_mis++; $error("FAIL accepted: bundle with tag %0d not accepted", tag); end
  endtask

  task automatic drain(input int max_cyc);
    bus.in_valid = 1'b0;
    for (int n = 0; n < max_cyc && sb.size() != 0; n++) step();
    n_vec++;
    if (sb.size() != 0) begin n_mis++; $error("FAIL drained: %0d bundles outstanding", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_op     = '0;
    bus8.in_a      = '0;
    bus8.in_b      = '0;
    bus8.in_tag    = '0;
    bus8.out_ready = 1'b1;
    #2;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_mis++; $error("FAIL rst_valid: observed 0x%0h", bus.out_valid); end
    n_vec++;
    if (bus.out_result !== 32'd0) begin n_mis++; $error("FAIL rst_result: observed 0x%0h", bus.out_result); end
    n_vec++;
    if (bus.out_tag !== 5'd0) begin n_mis++; $error("FAIL rst_tag: observed 0x%0h", bus.out_tag); end
    n_vec++;
    if (bus.out_zero !== 1'b0) begin n_mis++; $error("FAIL rst_zero: observed 0x%0h", bus.out_zero); end
    n_vec++;
    if (bus.out_ovf !== 1'b0) begin n_mis++; $error("FAIL rst_ovf: observed 0x%0h", bus.out_ovf); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_mis++; $error("FAIL rst_in_ready: observed 0x%0h", bus.in_ready); end
    n_vec++;
    if (bus8.out_valid !== 1'b0) begin n_mis++; $error("FAIL rst_valid8: observed 0x%0h", bus8.out_valid); end
    n_vec++;
    if (bus8.in_ready !== 1'b1) begin n_mis++; $error("FAIL rst_in_ready8: observed 0x%0h", bus8.in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed single ops, no stall
    issue(OP_XOR,  32'h0000_00AA, 32'h0000_0055, 5'd3,  32'h0000_00FF, 1'b0, 1'b0, 1'b1);
    issue(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd4,  32'h8000_0000, 1'b0, 1'b1, 1'b1);
    issue(OP_SUB,  32'h8000_0000, 32'h0000_0001, 5'd5,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    issue(OP_SUB,  32'd5,         32'd5,         5'd6,  32'd0,         1'b1, 1'b0, 1'b1);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd1,         5'd7,  32'd1,         1'b0, 1'b0, 1'b1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd8,  32'd0,         1'b1, 1'b0, 1'b1);
    issue(OP_SRA,  32'h8000_0000, 32'd4,         5'd9,  32'hF800_0000, 1'b0, 1'b0, 1'b1);
    issue(OP_MUL,  32'h0001_0000, 32'h0001_0000, 5'd10, 32'd0,         1'b1, 1'b0, 1'b1);
    issue(4'd12,   32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 32'd0,         1'b1, 1'b0, 1'b1);
    drain(10);

    // Six back-to-back ops with writeback stalled on stream cycles 3..5
    base     = cyc;
    stall_en = 1'b1;
    issue(OP_ADD, 32'd1,         32'd2,         5'd16, 32'd3,         1'b0, 1'b0, 1'b0);
    issue(OP_SUB, 32'd10,        32'd3,         5'd17, 32'd7,         1'b0, 1'b0, 1'b0);
    issue(OP_AND, 32'h0000_00F0, 32'h0000_003C, 5'd18, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    issue(OP_OR,  32'h0000_00F0, 32'h0000_000F, 5'd19, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    issue(OP_SLL, 32'd1,         32'd31,        5'd20, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    issue(OP_SRL, 32'h8000_0000, 32'd31,        5'd21, 32'd1,         1'b0, 1'b0, 1'b0);
    drain(20);
    stall_en = 1'b0;

    // Flush with two ops in flight and a third presented on the flush cycle
    issue(OP_ADD, 32'd1, 32'd1, 5'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 32'd2, 32'd2, 5'd2, 32'd4, 1'b0, 1'b0, 1'b0);
    rdy          = 1'b0;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_a     = 32'd3;
    bus.in_b     = 32'd3;
    bus.in_tag   = 5'd3;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    rdy          = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_mis++; $error("FAIL flushed_valid: observed 0x%0h", bus.out_valid); end
    end
    issue(OP_ADD, 32'd20, 32'd22, 5'd12, 32'd42, 1'b0, 1'b0, 1'b1);
    drain(10);

    // Asynchronous reset between edges with valid data at the output
    issue(OP_ADD, 32'd7, 32'd8, 5'd13, 32'd15, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 32'd1, 32'd1, 5'd14, 32'd2,  1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1) begin n_mis++; $error("FAIL pre_rst_valid: observed 0x%0h", bus.out_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_mis++; $error("FAIL async_rst_valid: observed 0x%0h", bus.out_valid); end
    n_vec++;
    if (bus.out_result !== 32'd0) begin n_mis++; $error("FAIL async_rst_result: observed 0x%0h", bus.out_result); end
    n_vec++;
    if (bus.out_tag !== 5'd0) begin n_mis++; $error("FAIL async_rst_tag: observed 0x%0h", bus.out_tag); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_mis++; $error("FAIL async_rst_in_ready: observed 0x%0h", bus.in_ready); end
    sb.delete();
    hold_prev = 1'b0;
    step();
    step();
    reset = 1'b0;
    issue(OP_ADD, 32'd2, 32'd3, 5'd2, 32'd5, 1'b0, 1'b0, 1'b1);
    drain(10);

    // 8-bit, single-stage instance: wrap to zero
    bus8.in_valid = 1'b1;
    bus8.in_op    = OP_ADD;
    bus8.in_a     = 8'hFF;
    bus8.in_b     = 8'h01;
    bus8.in_tag   = 5'd9;
    @(negedge clk);
    n_vec++;
    if (bus8.in_ready !== 1'b1) begin n_mis++; $error("FAIL w8_in_ready: observed 0x%0h", bus8.in_ready); end
    n_vec++;
    if (bus8.out_valid !== 1'b0) begin n_mis++; $error("FAIL w8_pre_valid: observed 0x%0h", bus8.out_valid); end
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus8.out_valid !== 1'b1) begin n_mis++; $error("FAIL w8_valid: observed 0x%0h", bus8.out_valid); end
    n_vec++;
    if (bus8.out_result !== 8'h00) begin n_mis++; $error("FAIL w8_result: observed 0x%0h", bus8.out_result); end
    n_vec++;
    if (bus8.out_tag !== 5'd9) begin n_mis++; $error("FAIL w8_tag: observed 0x%0h", bus8.out_tag); end
    n_vec++;
    if (bus8.out_zero !== 1'b1) begin n_mis++; $error("FAIL w8_zero: observed 0x%0h", bus8.out_zero); end
    n_vec++;
    if (bus8.out_ovf !== 1'b0) begin n_mis++; $error("FAIL w8_ovf: observed 0x%0h", bus8.out_ovf); end
    @(negedge clk);
    n_vec++;
    if (bus8.out_valid !== 1'b0) begin n_mis++; $error("FAIL w8_post_valid: observed 0x%0h", bus8.out_valid); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
